// File: rtl/mdio_pkg.sv
// mdio_pkg: shared Clause-22 MDIO constants and the master's FSM state type.
// The register address constants are also used by the PHY config FSM.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] TA_WR      = 2'b10;

  localparam logic [4:0] REG_BMCR       = 5'd0;
  localparam logic [4:0] REG_BMSR       = 5'd1;
  localparam logic [4:0] REG_PHYID1     = 5'd2;
  localparam logic [4:0] REG_PHYID2     = 5'd3;
  localparam logic [4:0] REG_ANAR       = 5'd4;
  localparam logic [4:0] REG_1000T_CTRL = 5'd9;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_PRE  = 6'b000010,
    S_HDR  = 6'b000100,
    S_TA   = 6'b001000,
    S_DATA = 6'b010000,
    S_END  = 6'b100000
  } state_t;

endpackage

// File: rtl/mdio_master_c22_mdc_tick_gen.sv
// mdc_tick_gen: MDC generator. Each MDC period is CLK_DIV cycles low then
// CLK_DIV cycles high; held low with the counter cleared while en=0.
// Ports:
//   clk, rst  clock, async active-high reset
//   en        frame active
//   mdc       management clock
//   fall_stb  last high cycle: mdc falls at the coming edge (launch next bit)
//   rise_stb  first high cycle of mdc (sample mdio)
module mdc_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // CLK_DIV >= 2 keeps the two strobes in different cycles.
  assign fall_stb = en && mdc && (cnt == LAST);
  assign rise_stb = en && mdc && (cnt == '0);

endmodule

// File: rtl/mdio_master_c22.sv
// mdio_master_c22: Clause-22 MDIO master. Takes one command, serializes
// PRE | ST | OP | PHYAD | REGAD | TA | DATA on MDC/MDIO, acks for one cycle.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cmd_valid/read/phy/reg/wdata  command (accepted when idle)
//   busy, ack, rdata, ta_err, cmd_drop  status / response
//   mdc, mdio_o, mdio_oe, mdio_i        pins (tri-state buffer lives above)
module mdio_master_c22
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        ta_err,
  output logic        cmd_drop,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  state_t      state;
  logic        rd_q;
  logic [15:0] wdata_q;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [15:0] rdata_q;
  logic [5:0]  bit_cnt;
  logic        ta_flag;
  logic [1:0]  sync;
  logic        fall_stb, rise_stb, tick_en;

  assign tick_en = (state == S_PRE) || (state == S_HDR) ||
                   (state == S_TA)  || (state == S_DATA);

  mdc_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (tick_en),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // mdio_i is asynchronous; idle value matches the board pull-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], mdio_i};
  end

  assign busy     = (state != S_IDLE);
  assign ack      = (state == S_END);
  assign ta_err   = ack && rd_q && ta_flag;
  assign rdata    = rdata_q;
  assign cmd_drop = cmd_valid && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata_q <= '0;
      bit_cnt <= '0;
      ta_flag <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
    end else begin
      // Read-side sampling, first high cycle of each bit.
      if (rise_stb && rd_q) begin
        if (state == S_TA && bit_cnt == 6'd1) ta_flag <= sync[1];
        if (state == S_DATA)                  rx_sr   <= {rx_sr[14:0], sync[1]};
      end

      case (state)
        S_IDLE: begin
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
          if (cmd_valid) begin
            state   <= S_PRE;
            rd_q    <= cmd_read;
            wdata_q <= cmd_wdata;
            tx_sr   <= {MDIO_ST, cmd_read ? MDIO_OP_RD : MDIO_OP_WR,
                        cmd_phy, cmd_reg, 2'b00};
            rx_sr   <= '0;
            bit_cnt <= '0;
            ta_flag <= 1'b0;
            mdio_o  <= 1'b1;   // first preamble bit
            mdio_oe <= 1'b1;
          end
        end
        S_PRE: if (fall_stb) begin
          if (bit_cnt == 6'(PRE_LEN - 1)) begin
            state   <= S_HDR;
            bit_cnt <= '0;
            mdio_o  <= tx_sr[15];
            tx_sr   <= tx_sr << 1;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_HDR: if (fall_stb) begin
          if (bit_cnt == 6'd13) begin
            state   <= S_TA;
            bit_cnt <= '0;
            mdio_o  <= rd_q ? 1'b1 : TA_WR[1];
            mdio_oe <= !rd_q;
          end else begin
            mdio_o  <= tx_sr[15];
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_TA: if (fall_stb) begin
          if (bit_cnt == 6'd0) begin
            mdio_o  <= rd_q ? 1'b1 : TA_WR[0];
            bit_cnt <= 6'd1;
          end else begin
            state   <= S_DATA;
            bit_cnt <= '0;
            mdio_o  <= rd_q ? 1'b1 : wdata_q[15];
            tx_sr   <= {wdata_q[14:0], 1'b0};
          end
        end
        S_DATA: if (fall_stb) begin
          if (bit_cnt == 6'd15) begin
            state   <= S_END;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            // All 16 samples are in by the last high phase.
            if (rd_q) rdata_q <= rx_sr;
          end else begin
            mdio_o  <= rd_q ? 1'b1 : tx_sr[15];
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_END: begin
          state   <= S_IDLE;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
